// File: rtl/aes_key_expansion.sv
// Iterative AES-128 key schedule: expands a 128-bit cipher key into w[0..43], one word per clock,
// and serves the four words of a selected round through a registered read port.
module aes_key_expansion #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned NUM_WORDS  = 44
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  key_start_in,
   input  logic [DATA_WIDTH-1:0] key_0_in,
   input  logic [DATA_WIDTH-1:0] key_1_in,
   input  logic [DATA_WIDTH-1:0] key_2_in,
   input  logic [DATA_WIDTH-1:0] key_3_in,
   input  logic [3:0]            round_sel_in,
   output logic [DATA_WIDTH-1:0] key_0_out,
   output logic [DATA_WIDTH-1:0] key_1_out,
   output logic [DATA_WIDTH-1:0] key_2_out,
   output logic [DATA_WIDTH-1:0] key_3_out,
   output logic                  key_busy_flag,
   output logic                  key_ready_flag
);

   localparam int unsigned CNT_W      = 6;
   localparam int unsigned LAST_ROUND = 10;

   // FIPS-197 S-box, entry 0 in the most significant byte
   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX[{~b, 3'b000} +: 8];
   endfunction

   typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

   state_t                  state_q, state_d;
   logic                    busy_d, ready_d;
   logic [DATA_WIDTH-1:0]   w [NUM_WORDS];
   logic [CNT_W-1:0]        cnt_q;
   logic [7:0]              rcon_q;
   logic [CNT_W-1:0]        cur_idx;
   logic [DATA_WIDTH-1:0]   prev_w, rot_w, sub_w, temp_w;
   logic [7:0]              rcon_next;
   logic [CNT_W-1:0]        rd_base;

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // next state: a start pulse wins over everything, including the final expansion step
   always_comb begin
      state_d = state_q;
      if (key_start_in) begin
         state_d = EXPAND;
      end else begin
         case (state_q)
            EXPAND:  if (cnt_q == CNT_W'(NUM_WORDS - 1)) state_d = DONE;
            default: state_d = state_q;
         endcase
      end
   end

   // flag decode from the upcoming state, registered below
   always_comb begin
      busy_d  = 1'b0;
      ready_d = 1'b0;
      case (state_d)
         EXPAND:  busy_d  = 1'b1;
         DONE:    ready_d = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         key_busy_flag  <= 1'b0;
         key_ready_flag <= 1'b0;
      end else begin
         key_busy_flag  <= busy_d;
         key_ready_flag <= ready_d;
      end
   end

   // round function for word i; index clamped so idle counter values never read out of range
   always_comb begin
      cur_idx   = (cnt_q < CNT_W'(4)) ? CNT_W'(4) : cnt_q;
      prev_w    = w[cur_idx - CNT_W'(1)];
      rot_w     = {prev_w[23:0], prev_w[31:24]};
      sub_w     = {sbox(rot_w[31:24]), sbox(rot_w[23:16]), sbox(rot_w[15:8]), sbox(rot_w[7:0])};
      rcon_next = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
      temp_w    = (cur_idx[1:0] == 2'b00) ? (sub_w ^ {rcon_q, 24'h000000}) : prev_w;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_WORDS; i++) w[i] <= '0;
         cnt_q  <= '0;
         rcon_q <= 8'h01;
      end else if (key_start_in) begin
         w[0]   <= key_0_in;
         w[1]   <= key_1_in;
         w[2]   <= key_2_in;
         w[3]   <= key_3_in;
         cnt_q  <= CNT_W'(4);
         rcon_q <= 8'h01;
      end else if (state_q == EXPAND) begin
         w[cur_idx] <= w[cur_idx - CNT_W'(4)] ^ temp_w;
         cnt_q      <= cnt_q + CNT_W'(1);
         if (cur_idx[1:0] == 2'b00) rcon_q <= rcon_next;
      end
   end

   assign rd_base = {round_sel_in, 2'b00};

   // read port returns raw array contents in every state; out-of-range rounds read as zero
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         key_0_out <= '0;
         key_1_out <= '0;
         key_2_out <= '0;
         key_3_out <= '0;
      end else if (round_sel_in > 4'(LAST_ROUND)) begin
         key_0_out <= '0;
         key_1_out <= '0;
         key_2_out <= '0;
         key_3_out <= '0;
      end else begin
         key_0_out <= w[rd_base];
         key_1_out <= w[rd_base + CNT_W'(1)];
         key_2_out <= w[rd_base + CNT_W'(2)];
         key_3_out <= w[rd_base + CNT_W'(3)];
      end
   end

endmodule

// File: doc/aes_key_expansion.md
Name: aes_key_expansion

Overview:
- Iterative AES-128 key schedule sitting directly upstream of the Cipher core.
- Accepts a 128-bit cipher key and expands it into the 44 round-key words w[0..43], one word per clock.
- Serves four words per round to Cipher's key_0_in..key_3_in, indexed by the same round counter that drives core_count_in.

Parameters:
- DATA_WIDTH, 32, word width; fixed at 32 for AES, other values unsupported.
- NUM_WORDS, 44, number of expanded words (Nb*(Nr+1)).

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- key_start_in  input  1  single-cycle pulse; loads key_0_in..key_3_in and starts expansion
- key_0_in  input  DATA_WIDTH  cipher key word 0 (bits 127:96)
- key_1_in  input  DATA_WIDTH  cipher key word 1
- key_2_in  input  DATA_WIDTH  cipher key word 2
- key_3_in  input  DATA_WIDTH  cipher key word 3 (bits 31:0)
- round_sel_in  input  4  round index 0..10 for the read port
- key_0_out  output  DATA_WIDTH  w[4*round_sel]
- key_1_out  output  DATA_WIDTH  w[4*round_sel+1]
- key_2_out  output  DATA_WIDTH  w[4*round_sel+2]
- key_3_out  output  DATA_WIDTH  w[4*round_sel+3]
- key_busy_flag  output  1  high while expansion is in progress
- key_ready_flag  output  1  high when all 44 words are valid

Behaviour:
- Reset (rst high, asynchronous): state=IDLE; w[0..43]=0; word counter=0; rcon=8'h01; all key_*_out=0; key_busy_flag=0; key_ready_flag=0.
- FSM states: IDLE, EXPAND, DONE.
- key_start_in sampled high in any state, including EXPAND (restart/abort):
  - w[0..3] <= key_0_in..key_3_in; counter <= 4; rcon <= 8'h01.
  - state <= EXPAND; key_busy_flag <= 1; key_ready_flag <= 0.
- EXPAND, each cycle with i = counter:
  - temp = w[i-1].
  - If i[1:0]==0: temp = SubWord(RotWord(temp)) ^ {rcon,24'h0}; rcon <= xtime(rcon), i.e. {rcon[6:0],1'b0} ^ (rcon[7] ? 8'h1b : 8'h00).
  - w[i] <= w[i-4] ^ temp; counter <= i+1.
  - RotWord = {b1,b2,b3,b0}. SubWord = four parallel FIPS-197 S-box lookups (combinational function, instantiated 4 times).
- Transition: when the write of w[43] completes, state <= DONE, key_busy_flag <= 0, key_ready_flag <= 1 (same edge).
- Latency: start sampled at edge T; w[4..43] written at edges T+1..T+40; key_ready_flag visible high after edge T+40.
- Rcon sequence over rounds 1..10: 01,02,04,08,10,20,40,80,1b,36.
- DONE: holds the key schedule until the next key_start_in or rst.
- Read port:
  - Registered; key_n_out <= w[4*round_sel_in+n] on every clock, in any state. One-cycle latency.
  - round_sel_in > 10: all four outputs <= 0.
  - During EXPAND the read port still returns current array contents. These are valid only when key_ready_flag=1; Cipher must not be sequenced before ready.
- Simultaneous key_start_in on the edge that would write w[43]: start wins; ready stays 0 and expansion restarts from the new key.
- rst asserted mid-expansion: everything returns to reset values immediately.

Test Plan:
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, pulse start, wait for ready -> ready rises exactly 40 cycles after the start edge; busy high for those 40 cycles.
- Same key, round_sel=1 -> next cycle outputs a0fafe17 88542cb1 23a33939 2a6c7605.
- Same key, round_sel=10 -> outputs d014f9a8 c9ee2589 e13f0cc8 b6630ca6.
- Same key, round_sel=0 -> outputs 2b7e1516 28aed2a6 abf71588 09cf4f3c.
- All-zero key -> round 1 = 62636363 x4; round 10 = b4ef5bcb 3e92e211 23e951cf 6f8f188e.
- Restart, reset and out-of-range read:
  - Start with the zero key, re-pulse start with the FIPS key at cycle 20 -> ready only 40 cycles after the second start; round 10 = d014f9a8 ...
  - Assert rst mid-EXPAND -> outputs, busy and ready all 0 asynchronously.
  - round_sel=12 -> all outputs 0.
